nibble_sequencer: RTL and testbench

Fetch/execute controller for the 4-bit processor datapath (12-bit program counter, program ROM, 8-bit fetch register split into 4-bit `instruccion` and 4-bit `operando`). It alternates FETCH and EXEC phases and drives the counter increment/load and fetch-register enables. It decodes the latched opcode into accumulator/ALU/output controls, holds the carry and zero flags, and resolves conditional jumps. It sits between the fetch stage and the ALU/accumulator and is the only source of those enables.

---
 rtl/nibble_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nibble_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sequencer.sv
// Fetch/execute controller for the 4-bit processor: alternates FETCH/EXEC,
// decodes the latched opcode into datapath enables, and owns the carry/zero flags.
module nibble_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] instruccion,
    input  logic       c_in,
    input  logic       z_in,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       fetch_ena,
    output logic       acc_ena,
    output logic       bus_oe,
    output logic [2:0] alu_sel,
    output logic       out_ena,
    output logic       carry,
    output logic       zero,
    output logic       phase,
    output logic       halted,
    output logic [7:0] retired
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_CMPI  = 4'h4;
    localparam logic [3:0] OP_NANDI = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_JC    = 4'h7;
    localparam logic [3:0] OP_JNC   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_JNZ   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_HLT   = 4'hF;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_PASS_B = 3'b011;
    localparam logic [2:0] ALU_NAND   = 3'b100;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       carry_reg;
    logic       zero_reg;
    logic [7:0] retired_reg;
    logic       in_exec;
    logic       flag_upd;

    assign in_exec = (state_reg == ST_EXEC);

    // Only the ALU-producing opcodes (LIT..NANDI) capture the raw flags.
    assign flag_upd = in_exec && (instruccion >= OP_LIT) && (instruccion <= OP_NANDI);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (run) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
                if (instruccion == OP_HLT) state_next = ST_HALT;
                else if (!run)             state_next = ST_IDLE;
                else                       state_next = ST_FETCH;
            end
            default:  state_next = ST_HALT;
        endcase
    end

    always_comb begin
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        fetch_ena = 1'b0;
        acc_ena   = 1'b0;
        bus_oe    = 1'b0;
        alu_sel   = ALU_PASS_A;
        out_ena   = 1'b0;
        if (state_reg == ST_FETCH) begin
            fetch_ena = 1'b1;
        end else if (in_exec) begin
            case (instruccion)
                OP_NOP: pc_inc = 1'b1;
                OP_LIT: begin
                    acc_ena = 1'b1;
                    bus_oe  = 1'b1;
                    alu_sel = ALU_PASS_B;
                    pc_inc  = 1'b1;
                end
                OP_ADDI: begin
                    acc_ena = 1'b1;
                    bus_oe  = 1'b1;
                    alu_sel = ALU_ADD;
                    pc_inc  = 1'b1;
                end
                OP_SUBI: begin
                    acc_ena = 1'b1;
                    bus_oe  = 1'b1;
                    alu_sel = ALU_SUB;
                    pc_inc  = 1'b1;
                end
                OP_CMPI: begin
                    bus_oe  = 1'b1;
                    alu_sel = ALU_SUB;
                    pc_inc  = 1'b1;
                end
                OP_NANDI: begin
                    acc_ena = 1'b1;
                    bus_oe  = 1'b1;
                    alu_sel = ALU_NAND;
                    pc_inc  = 1'b1;
                end
                OP_OUT: begin
                    out_ena = 1'b1;
                    alu_sel = ALU_PASS_A;
                    pc_inc  = 1'b1;
                end
                // Conditional jumps test the registered flags, never the raw ALU outputs.
                OP_JC: begin
                    pc_load = carry_reg;
                    pc_inc  = !carry_reg;
                end
                OP_JNC: begin
                    pc_load = !carry_reg;
                    pc_inc  = carry_reg;
                end
                OP_JZ: begin
                    pc_load = zero_reg;
                    pc_inc  = !zero_reg;
                end
                OP_JNZ: begin
                    pc_load = !zero_reg;
                    pc_inc  = zero_reg;
                end
                OP_JMP: pc_load = 1'b1;
                OP_HLT: pc_inc  = 1'b0;
                default: pc_inc = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b0;
            retired_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (flag_upd) begin
                carry_reg <= c_in;
                zero_reg  <= z_in;
            end
            if (in_exec) retired_reg <= retired_reg + 8'd1;
        end
    end

    assign carry   = carry_reg;
    assign zero    = zero_reg;
    assign retired = retired_reg;
    assign phase   = in_exec;
    assign halted  = (state_reg == ST_HALT);

endmodule

// File: tb/tb_nibble_sequencer.sv
// Directed bench for nibble_sequencer: walks reset, NOP stream, flag/jump
// decode, run drop, mid-EXEC reset, HLT and retired-counter wrap.
module tb_nibble_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] instruccion;
    logic       c_in;
    logic       z_in;
    logic       pc_inc;
    logic       pc_load;
    logic       fetch_ena;
    logic       acc_ena;
    logic       bus_oe;
    logic [2:0] alu_sel;
    logic       out_ena;
    logic       carry;
    logic       zero;
    logic       phase;
    logic       halted;
    logic [7:0] retired;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nibble_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instruccion (instruccion),
        .c_in        (c_in),
        .z_in        (z_in),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .fetch_ena   (fetch_ena),
        .acc_ena     (acc_ena),
        .bus_oe      (bus_oe),
        .alu_sel     (alu_sel),
        .out_ena     (out_ena),
        .carry       (carry),
        .zero        (zero),
        .phase       (phase),
        .halted      (halted),
        .retired     (retired)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs the control outputs into one byte: {pc_inc,pc_load,fetch_ena,acc_ena,bus_oe,out_ena,phase,halted}
    function automatic logic [7:0] ctl();
        return {pc_inc, pc_load, fetch_ena, acc_ena, bus_oe, out_ena, phase, halted};
    endfunction

    initial begin
        reset = 1'b0; run = 1'b0; instruccion = 4'h0; c_in = 1'b0; z_in = 1'b0;
        step(); step();
        chk("reset_ctl", ctl(), 8'h00);
        chk("reset_alu", {5'd0, alu_sel}, 8'h00);
        chk("reset_retired", retired, 8'h00);
        chk("reset_flags", {6'd0, carry, zero}, 8'h00);

        // Release with run=1: next edge enters FETCH
        reset = 1'b1; run = 1'b1;
        step();
        chk("fetch1_ctl", ctl(), 8'b0010_0000);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("nop_exec_ctl", ctl(), 8'b1000_0010);
            step();
            chk("nop_fetch_ctl", ctl(), 8'b0010_0000);
            chk("nop_retired", retired, 8'(i));
        end

        // LIT 5 with c_in=0, z_in=0
        instruccion = 4'h1; c_in = 1'b0; z_in = 1'b0;
        step();
        chk("lit_ctl", ctl(), 8'b1001_1010);
        chk("lit_alu", {5'd0, alu_sel}, 8'h03);
        step();
        chk("lit_flags", {6'd0, carry, zero}, 8'h00);

        // CMPI 5 with c_in=1, z_in=1: flags update, accumulator untouched
        instruccion = 4'h4; c_in = 1'b1; z_in = 1'b1;
        step();
        chk("cmpi_ctl", ctl(), 8'b1000_1010);
        chk("cmpi_alu", {5'd0, alu_sel}, 8'h01);
        step();
        chk("cmpi_flags", {6'd0, carry, zero}, 8'h03);

        // JZ with zero=1, raw inputs deliberately opposite
        instruccion = 4'h9; c_in = 1'b0; z_in = 1'b0;
        step();
        chk("jz_taken_ctl", ctl(), 8'b0100_0010);
        step();
        chk("jz_flags_held", {6'd0, carry, zero}, 8'h03);

        instruccion = 4'hA;
        step();
        chk("jnz_not_taken_ctl", ctl(), 8'b1000_0010);
        step();

        // LIT with c_in=0, z_in=1 -> carry=0, zero=1
        instruccion = 4'h1; c_in = 1'b0; z_in = 1'b1;
        step(); step();
        chk("lit2_flags", {6'd0, carry, zero}, 8'h01);

        instruccion = 4'h7; c_in = 1'b1;
        step();
        chk("jc_not_taken_ctl", ctl(), 8'b1000_0010);
        step();
        instruccion = 4'h8;
        step();
        chk("jnc_taken_ctl", ctl(), 8'b0100_0010);
        step();
        instruccion = 4'hB;
        step();
        chk("jmp_ctl", ctl(), 8'b0100_0010);
        step();
        instruccion = 4'h6;
        step();
        chk("out_ctl", ctl(), 8'b1000_0110);
        chk("out_alu", {5'd0, alu_sel}, 8'h00);
        step();
        chk("out_flags_held", {6'd0, carry, zero}, 8'h01);
        instruccion = 4'h5; c_in = 1'b0; z_in = 1'b0;
        step();
        chk("nandi_ctl", ctl(), 8'b1001_1010);
        chk("nandi_alu", {5'd0, alu_sel}, 8'h04);
        step();
        chk("nandi_flags", {6'd0, carry, zero}, 8'h00);
        instruccion = 4'hC; c_in = 1'b1; z_in = 1'b1;
        step();
        chk("rsvd_ctl", ctl(), 8'b1000_0010);
        step();
        chk("rsvd_flags_held", {6'd0, carry, zero}, 8'h00);
        chk("retired_mid", retired, 8'd14);

        // Drop run during FETCH: instruction completes, then IDLE
        run = 1'b0; instruccion = 4'h0;
        step();
        chk("rundrop_exec_ctl", ctl(), 8'b1000_0010);
        step();
        chk("rundrop_idle_ctl", ctl(), 8'h00);
        step();
        chk("idle_hold_ctl", ctl(), 8'h00);
        chk("idle_retired", retired, 8'd15);
        run = 1'b1;
        step();
        chk("idle_to_fetch_ctl", ctl(), 8'b0010_0000);

        // Reset asserted mid-EXEC of ADDI with c_in=1
        instruccion = 4'h2; c_in = 1'b1; z_in = 1'b1;
        step();
        chk("addi_ctl", ctl(), 8'b1001_1010);
        chk("addi_alu", {5'd0, alu_sel}, 8'h02);
        reset = 1'b0;
        #1;
        chk("midreset_ctl", ctl(), 8'h00);
        chk("midreset_alu", {5'd0, alu_sel}, 8'h00);
        chk("midreset_retired", retired, 8'h00);
        step();
        chk("midreset_flags", {6'd0, carry, zero}, 8'h00);

        // HLT
        reset = 1'b1; run = 1'b1; instruccion = 4'hF;
        step();
        step();
        chk("hlt_exec_ctl", ctl(), 8'b0000_0010);
        step();
        chk("halt_ctl", ctl(), 8'b0000_0001);
        chk("halt_retired", retired, 8'd1);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            instruccion = 4'(i);
            step();
            chk("halt_hold_ctl", ctl(), 8'b0000_0001);
            chk("halt_hold_retired", retired, 8'd1);
        end
        reset = 1'b0;
        #1;
        chk("halt_reset_ctl", ctl(), 8'h00);
        chk("halt_reset_retired", retired, 8'h00);

        // 256 NOPs: retired wraps FF -> 00
        step();
        reset = 1'b1; run = 1'b1; instruccion = 4'h0;
        step();
        for (int i = 1; i <= 256; i++) begin
            step(); step();
            if (i == 255) chk("wrap_ff", retired, 8'hFF);
        end
        chk("wrap_00", retired, 8'h00);
        chk("wrap_fetch_ctl", ctl(), 8'b0010_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
